// File: rtl/io_stream_interface.sv
// Buffered host I/O block: the input FIFO feeds the decompressor and the output FIFO feeds the host.
// A load-driven mode FSM selects which FIFO may accept new words.

// Generic first-word-fall-through FIFO; rdata is 0 when empty.
// Latency: 1 cycle from push to rdata/count. Backpressure: the caller gates push/pop.
module io_stream_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = (cnt != '0) ? mem[rptr] : '0;
  assign count = cnt;
endmodule

// Top-level stream interface: mode FSM, input and output FIFOs, and a saturating loaded-word counter.
// Latency: 1 cycle from an accepted word to the FIFO head. Backpressure: ready drops when the FIFO is full or the mode is wrong.
module io_stream_interface #(
  parameter int DIN_W = 16,
  parameter int RES_W = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DIN_W-1:0]       din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [DIN_W-1:0]       decomp_data,
  output logic                   decomp_valid,
  input  logic                   decomp_ready,
  input  logic [RES_W-1:0]       results,
  input  logic                   results_valid,
  output logic                   results_ready,
  output logic [RES_W-1:0]       dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] in_count,
  output logic [$clog2(DEPTH):0] out_count,
  output logic [CNT_W-1:0]       loaded_words
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FLUSH  = 2'd2,
    OUTPUT = 2'd3
  } st_t;

  st_t  state_q, state_d;
  logic in_push, in_pop, out_push, out_pop;
  logic enter_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FLUSH waits for the decompressor to empty the input FIFO before results are accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = load ? LOAD : OUTPUT;
      LOAD:    if (!load) state_d = FLUSH;
      FLUSH:   if (load) state_d = LOAD;
               else if (in_count == '0) state_d = OUTPUT;
      OUTPUT:  if (load) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  assign state      = state_q;
  assign enter_load = (state_d == LOAD) && (state_q != LOAD);

  assign din_ready     = (state_q == LOAD) && (in_count < FULL);
  assign results_ready = (state_q == OUTPUT) && (out_count < FULL);
  assign decomp_valid  = (in_count != '0);
  assign dout_valid    = (out_count != '0);

  assign in_push  = din_valid && din_ready;
  assign out_push = results_valid && results_ready;
  assign in_pop   = decomp_valid && decomp_ready && (state_q != IDLE);
  assign out_pop  = dout_valid && dout_ready && (state_q != IDLE);

  io_stream_fifo #(.W(DIN_W), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .pop   (in_pop),
    .wdata (din),
    .rdata (decomp_data),
    .count (in_count)
  );

  io_stream_fifo #(.W(RES_W), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (results),
    .rdata (dout),
    .count (out_count)
  );

  // Entering LOAD clears the counter; no push can coincide since din_ready is low outside LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 loaded_words <= '0;
    else if (enter_load)                     loaded_words <= '0;
    else if (in_push && (loaded_words != '1)) loaded_words <= loaded_words + 1'b1;
  end
endmodule

// File: tb/tb_io_stream_interface.sv
// Randomized and directed bench for io_stream_interface against a queue-based reference model.
module tb_io_stream_interface;
  localparam int DIN_W = 16;
  localparam int RES_W = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 3;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic [DIN_W-1:0] din = '0;
  logic din_valid = 1'b0;
  logic din_ready;
  logic [DIN_W-1:0] decomp_data;
  logic decomp_valid;
  logic decomp_ready = 1'b0;
  logic [RES_W-1:0] results = '0;
  logic results_valid = 1'b0;
  logic results_ready;
  logic [RES_W-1:0] dout;
  logic dout_valid;
  logic dout_ready = 1'b0;
  logic [1:0] state;
  logic [CW-1:0] in_count, out_count;
  logic [CNT_W-1:0] loaded_words;

  io_stream_interface #(.DIN_W(DIN_W), .RES_W(RES_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .load(load),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .decomp_data(decomp_data), .decomp_valid(decomp_valid), .decomp_ready(decomp_ready),
    .results(results), .results_valid(results_valid), .results_ready(results_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .state(state), .in_count(in_count), .out_count(out_count), .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: mode number, two queues, and the loaded counter.
  int mstate = 0;
  logic [DIN_W-1:0] inq[$];
  logic [RES_W-1:0] outq[$];
  int mloaded = 0;
  bit last_in_push = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    inq.delete();
    outq.delete();
    mstate  = 0;
    mloaded = 0;
  endtask

  // Check all outputs against the model, advance the model, then move to the next falling edge.
  task automatic tick();
    bit dr, rr, pin, pout, pi, po;
    int ns;
    dr = (mstate == 1) && (inq.size() < DEPTH);
    rr = (mstate == 3) && (outq.size() < DEPTH);
    chk("state", 32'(state), 32'(mstate));
    chk("in_count", 32'(in_count), 32'(inq.size()));
    chk("out_count", 32'(out_count), 32'(outq.size()));
    chk("loaded_words", 32'(loaded_words), 32'(mloaded));
    chk("din_ready", 32'(din_ready), 32'(dr));
    chk("results_ready", 32'(results_ready), 32'(rr));
    chk("decomp_valid", 32'(decomp_valid), 32'(inq.size() != 0));
    chk("decomp_data", 32'(decomp_data), (inq.size() != 0) ? 32'(inq[0]) : 32'd0);
    chk("dout_valid", 32'(dout_valid), 32'(outq.size() != 0));
    chk("dout", 32'(dout), (outq.size() != 0) ? 32'(outq[0]) : 32'd0);

    pin  = din_valid && dr;
    pout = results_valid && rr;
    pi   = (inq.size() != 0) && decomp_ready && (mstate != 0);
    po   = (outq.size() != 0) && dout_ready && (mstate != 0);

    case (mstate)
      0:       ns = load ? 1 : 3;
      1:       ns = load ? 1 : 2;
      2:       ns = load ? 1 : ((inq.size() == 0) ? 3 : 2);
      default: ns = load ? 1 : 3;
    endcase
    if (ns == 1 && mstate != 1) mloaded = 0;
    else if (pin && mloaded < SAT) mloaded++;

    if (pi) void'(inq.pop_front());
    if (po) void'(outq.pop_front());
    if (pin) inq.push_back(din);
    if (pout) outq.push_back(results);
    mstate = ns;
    last_in_push = pin;

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [DIN_W-1:0] words[9];
    logic [RES_W-1:0] res3[3];
    int k, guard;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_in_count", 32'(in_count), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_loaded", 32'(loaded_words), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_results_ready", 32'(results_ready), 32'd0);
    chk("rst_decomp_valid", 32'(decomp_valid), 32'd0);
    chk("rst_decomp_data", 32'(decomp_data), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    model_reset();

    // Load burst
    load = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      din = 16'(i * 16'h1111);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    chk("burst_in_count", 32'(in_count), 32'd4);
    chk("burst_loaded", 32'(loaded_words), 32'd4);
    chk("burst_head", 32'(decomp_data), 32'h1111);
    decomp_ready = 1'b1;
    repeat (5) tick();

    // Input full: word 9 is held until one pop makes room
    decomp_ready = 1'b0;
    for (int i = 0; i < 9; i++) words[i] = 16'($urandom);
    k = 0;
    guard = 0;
    while (k < 9 && guard < 40) begin
      din = words[k];
      din_valid = 1'b1;
      decomp_ready = (guard == 12);
      if (guard == 10) chk("full_din_ready", 32'(din_ready), 32'd0);
      tick();
      if (last_in_push) k++;
      guard++;
    end
    chk("full_all_accepted", 32'(k), 32'd9);
    chk("full_loaded_sat", 32'(loaded_words), 32'(SAT));
    din_valid = 1'b0;
    decomp_ready = 1'b0;
    tick();

    // Flush gating: leave one cycle of draining, then refill to 3 words
    decomp_ready = 1'b1;
    repeat (9) tick();
    decomp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 16'($urandom);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    load = 1'b0;
    repeat (3) tick();
    chk("flush_state", 32'(state), 32'd2);
    chk("flush_results_ready", 32'(results_ready), 32'd0);
    decomp_ready = 1'b1;
    repeat (5) tick();
    chk("flush_to_output", 32'(state), 32'd3);

    // Result stream with simultaneous push/pop
    res3[0] = 4'h3; res3[1] = 4'hA; res3[2] = 4'hF;
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      results = res3[i];
      results_valid = 1'b1;
      tick();
      chk("stream_dout", 32'(dout), 32'(res3[i]));
      chk("stream_out_count", 32'(out_count), 32'd1);
    end
    results_valid = 1'b0;
    repeat (2) tick();

    // Mode re-entry while results are buffered
    dout_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      results = 4'($urandom);
      results_valid = 1'b1;
      tick();
    end
    results_valid = 1'b0;
    load = 1'b1;
    tick();
    chk("reentry_state", 32'(state), 32'd1);
    chk("reentry_loaded", 32'(loaded_words), 32'd0);
    chk("reentry_results_ready", 32'(results_ready), 32'd0);
    dout_ready = 1'b1;
    repeat (3) tick();
    chk("reentry_drained", 32'(out_count), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      if (c % 16 == 0) load = 1'($urandom_range(0, 1));
      din = 16'($urandom);
      din_valid = 1'($urandom_range(0, 1));
      decomp_ready = ($urandom_range(0, 3) != 0);
      results = 4'($urandom);
      results_valid = 1'($urandom_range(0, 1));
      dout_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Async reset mid-burst
    din_valid = 1'b0; results_valid = 1'b0; decomp_ready = 1'b1; dout_ready = 1'b1;
    load = 1'b0;
    repeat (12) tick();
    decomp_ready = 1'b0;
    load = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      din = 16'($urandom);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    chk("pre_reset_in_count", 32'(in_count), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_in_count", 32'(in_count), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_decomp_valid", 32'(decomp_valid), 32'd0);
    chk("async_loaded", 32'(loaded_words), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
